// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO PHY-side target with a 32x16 register file.
// MDC is oversampled in the clk_in_clk domain; each detected MDC rise
// advances the frame decoder by one bit.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd0,
  parameter int          PREAMBLE_LEN = 32,
  parameter logic [15:0] PHY_ID1      = 16'h0141,
  parameter logic [15:0] PHY_ID2      = 16'h0DD1,
  parameter logic [15:0] BMSR_BASE    = 16'h7949
) (
  input  logic        clk_in_clk,
  input  logic        rst_in_reset,
  input  logic        mdio_mdc,
  input  logic        mdio_mdio_out,
  input  logic        mdio_mdio_oen,
  output logic        mdio_mdio_in,
  input  logic        link_up,
  output logic        reg_wr_valid,
  output logic [4:0]  reg_wr_addr,
  output logic [15:0] reg_wr_data,
  output logic        soft_reset,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA
  } state_t;

  localparam int PCW = $clog2(PREAMBLE_LEN + 1);
  localparam logic [PCW-1:0] PRE_MAX = PCW'(PREAMBLE_LEN);

  logic [1:0]     mdc_sync_q;
  logic           mdc_dly_q;
  logic           rise;
  logic           bus_bit;
  logic [4:0]     rd_addr;
  logic [15:0]    rd_data;
  logic [15:0]    regs_q [32];

  state_t         state_q, state_d;
  logic [PCW-1:0] pre_cnt_q, pre_cnt_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic           is_read_q, is_read_d;
  logic [4:0]     phyad_q, phyad_d;
  logic [4:0]     regad_q, regad_d;
  logic [15:0]    shift_q, shift_d;
  logic           drive_en_q, drive_en_d;
  logic           drive_val_q, drive_val_d;
  logic           contention_q, contention_d;
  logic           mdio_in_q;
  logic           wr_valid_q, wr_valid_d;
  logic [4:0]     wr_addr_q, wr_addr_d;
  logic [15:0]    wr_data_q, wr_data_d;
  logic           soft_reset_q, soft_reset_d;
  logic           frame_err_q, frame_err_d;

  // Rise of the synchronised MDC; bus resolved with master priority and pull-up.
  assign rise    = mdc_sync_q[1] & ~mdc_dly_q;
  assign bus_bit = !mdio_mdio_oen ? mdio_mdio_out : (drive_en_q ? drive_val_q : 1'b1);
  assign rd_addr = {regad_q[3:0], bus_bit};

  assign mdio_mdio_in = mdio_in_q;
  assign reg_wr_valid = wr_valid_q;
  assign reg_wr_addr  = wr_addr_q;
  assign reg_wr_data  = wr_data_q;
  assign soft_reset   = soft_reset_q;
  assign frame_err    = frame_err_q;

  // Read mux: reg 1 is built from link_up, regs 2/3 are constant IDs.
  always_comb begin
    rd_data = regs_q[rd_addr];
    case (rd_addr)
      5'd1:    rd_data = {BMSR_BASE[15:3], link_up, BMSR_BASE[1:0]};
      5'd2:    rd_data = PHY_ID1;
      5'd3:    rd_data = PHY_ID2;
      default: ;
    endcase
  end

  // Frame decoder: next state, drive control and output pulses.
  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    is_read_d    = is_read_q;
    phyad_d      = phyad_q;
    regad_d      = regad_q;
    shift_d      = shift_q;
    drive_en_d   = drive_en_q;
    drive_val_d  = drive_val_q;
    contention_d = contention_q;
    wr_valid_d   = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    soft_reset_d = 1'b0;
    frame_err_d  = 1'b0;

    // Master and responder both driving: flag once per drive window.
    if (!drive_en_q) begin
      contention_d = 1'b0;
    end else if (!mdio_mdio_oen && !contention_q) begin
      contention_d = 1'b1;
      frame_err_d  = 1'b1;
    end

    if (rise) begin
      case (state_q)
        S_IDLE: begin
          if (bus_bit) begin
            if (pre_cnt_q != PRE_MAX) pre_cnt_d = pre_cnt_q + 1'b1;
          end else begin
            if (pre_cnt_q == PRE_MAX) state_d = S_ST;
            pre_cnt_d = '0;
          end
        end
        S_ST: begin
          if (bus_bit) begin
            state_d   = S_OP;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
        S_OP: begin
          if (bit_cnt_q == 4'd0) begin
            shift_d[0] = bus_bit;
            bit_cnt_d  = 4'd1;
          end else if (shift_q[0] != bus_bit) begin
            is_read_d = shift_q[0];
            state_d   = S_PHYAD;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
        S_PHYAD: begin
          phyad_d   = {phyad_q[3:0], bus_bit};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'd4) begin
            state_d   = S_REGAD;
            bit_cnt_d = '0;
          end
        end
        S_REGAD: begin
          regad_d   = rd_addr;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'd4) begin
            bit_cnt_d = '0;
            if (phyad_q != PHY_ADDR) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_TA;
              if (is_read_q) shift_d = rd_data;
            end
          end
        end
        S_TA: begin
          if (is_read_q) begin
            if (bit_cnt_q == 4'd0) begin
              drive_en_d  = 1'b1;
              drive_val_d = 1'b0;
              bit_cnt_d   = 4'd1;
            end else begin
              drive_val_d = shift_q[15];
              shift_d     = {shift_q[14:0], 1'b0};
              state_d     = S_DATA;
              bit_cnt_d   = '0;
            end
          end else if (bit_cnt_q == 4'd0 && bus_bit) begin
            bit_cnt_d = 4'd1;
          end else if (bit_cnt_q == 4'd1 && !bus_bit) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
        S_DATA: begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (is_read_q) begin
            if (bit_cnt_q == 4'd15) begin
              drive_en_d  = 1'b0;
              drive_val_d = 1'b0;
              state_d     = S_IDLE;
            end else begin
              drive_val_d = shift_q[15];
              shift_d     = {shift_q[14:0], 1'b0};
            end
          end else begin
            shift_d = {shift_q[14:0], bus_bit};
            if (bit_cnt_q == 4'd15) begin
              wr_valid_d   = 1'b1;
              wr_addr_d    = regad_q;
              wr_data_d    = {shift_q[14:0], bus_bit};
              soft_reset_d = (regad_q == 5'd0) && shift_q[14];
              state_d      = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers, plus MDC synchroniser and registered bus echo.
  always_ff @(posedge clk_in_clk) begin
    if (rst_in_reset) begin
      mdc_sync_q   <= '0;
      mdc_dly_q    <= 1'b0;
      mdio_in_q    <= 1'b1;
      state_q      <= S_IDLE;
      pre_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      is_read_q    <= 1'b0;
      phyad_q      <= '0;
      regad_q      <= '0;
      shift_q      <= '0;
      drive_en_q   <= 1'b0;
      drive_val_q  <= 1'b0;
      contention_q <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      soft_reset_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      mdc_sync_q   <= {mdc_sync_q[0], mdio_mdc};
      mdc_dly_q    <= mdc_sync_q[1];
      mdio_in_q    <= bus_bit;
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      is_read_q    <= is_read_d;
      phyad_q      <= phyad_d;
      regad_q      <= regad_d;
      shift_q      <= shift_d;
      drive_en_q   <= drive_en_d;
      drive_val_q  <= drive_val_d;
      contention_q <= contention_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      soft_reset_q <= soft_reset_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Register file update on each committed write; regs 1..3 are read-only.
  always_ff @(posedge clk_in_clk) begin
    if (rst_in_reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_valid_q) begin
      if (wr_addr_q == 5'd0) regs_q[0] <= {1'b0, wr_data_q[14:0]};
      else if (wr_addr_q > 5'd3) regs_q[wr_addr_q] <= wr_data_q;
    end
  end

endmodule
